pulse_cmd_sender: RTL

Host-side initiator for the pulse-parameter command protocol.
- Serialises one command frame onto a UART byte transmitter: 4 data bytes, LSB first, then 1 control byte.
- Waits for the 1-byte checksum echo and compares it with the locally computed sum.
- Used by test benches and by a master FPGA that programs a pulse-generator board over RS232.

---
 rtl/pulse_cmd_sender.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_cmd_sender.sv
// Host-side initiator: sends 4 payload bytes (LSB first) plus a control byte through a
// UART byte transmitter, then checks the returned checksum echo. Optional macro: CMD_RETRY_EN.
module pulse_cmd_sender #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cmd_data,
  input  logic [7:0]  cmd_ctrl,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  output logic        busy,
  output logic        done,
  output logic        ack_ok,
  output logic        ack_err,
  output logic        timeout,
  output logic [7:0]  echo_byte,
  output logic [1:0]  retry_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 32;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(4);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  // retry_count is 2 bits wide and a zero timeout has no meaning
  if (TIMEOUT_CYCLES == 0 || MAX_RETRY > 3) begin : g_param_check
    $error("pulse_cmd_sender: TIMEOUT_CYCLES must be > 0 and MAX_RETRY <= 3");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_WAIT   = 3'd1,
    TX_STROBE = 3'd2,
    TX_HOLD   = 3'd3,
    TX_DRAIN  = 3'd4,
    ECHO_WAIT = 3'd5,
    DONE      = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BYTE_W-1:0]   ctrl_q, ctrl_d;
  logic [BYTE_W-1:0]   expected_q, expected_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                transmit_q, transmit_d;
  logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ack_ok_q, ack_ok_d;
  logic                ack_err_q, ack_err_d;
  logic                timeout_q, timeout_d;
  logic [BYTE_W-1:0]   echo_byte_q, echo_byte_d;

  logic accept_c, in_wait_c, progress_c, expire_c;
  logic echo_hit_c, echo_match_c, fail_c, retry_ok_c, retry_take_c;

  function automatic logic [7:0] checksum(input logic [31:0] d);
    checksum = d[7:0] + d[15:8] + d[23:16] + d[31:24];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [31:0] d, input logic [7:0] c,
                                            input logic [2:0] i);
    case (i)
      3'd0:    frame_byte = d[7:0];
      3'd1:    frame_byte = d[15:8];
      3'd2:    frame_byte = d[23:16];
      3'd3:    frame_byte = d[31:24];
      default: frame_byte = c;
    endcase
  endfunction

  assign accept_c     = (state_q == IDLE) && start;
  assign in_wait_c    = state_q inside {TX_WAIT, TX_HOLD, TX_DRAIN, ECHO_WAIT};
  assign echo_hit_c   = (state_q == ECHO_WAIT) && received;
  assign echo_match_c = (rx_byte == expected_q);

  // Condition that lets the current wait state advance this cycle
  always_comb begin
    progress_c = 1'b0;
    unique case (state_q)
      TX_WAIT, TX_DRAIN: progress_c = !is_transmitting;
      TX_HOLD:           progress_c = is_transmitting;
      ECHO_WAIT:         progress_c = received;
      default:           progress_c = 1'b0;
    endcase
  end

  // wait_cnt_q counts cycles already spent, so the limit is hit on the last allowed cycle;
  // progress in that same cycle (e.g. an echo) takes priority over the abort
  assign expire_c     = in_wait_c && !progress_c && (wait_cnt_q == LIMIT_CNT);
  assign fail_c       = expire_c || (echo_hit_c && !echo_match_c);
  assign retry_take_c = fail_c && retry_ok_c;

`ifdef CMD_RETRY_EN
  logic [1:0] retry_count_q, retry_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_count_q <= 2'b00;
    end else begin
      retry_count_q <= retry_count_d;
    end
  end

  always_comb begin
    retry_count_d = retry_count_q;
    if (accept_c) begin
      retry_count_d = 2'b00;
    end else if (retry_take_c) begin
      retry_count_d = retry_count_q + 2'd1;
    end
  end

  assign retry_ok_c  = (retry_count_q < 2'(MAX_RETRY));
  assign retry_count = retry_count_q;
`else
  assign retry_ok_c  = 1'b0;
  assign retry_count = 2'b00;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      ctrl_q      <= '0;
      expected_q  <= '0;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      transmit_q  <= 1'b0;
      tx_byte_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_ok_q    <= 1'b0;
      ack_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      echo_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      expected_q  <= expected_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      transmit_q  <= transmit_d;
      tx_byte_q   <= tx_byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_ok_q    <= ack_ok_d;
      ack_err_q   <= ack_err_d;
      timeout_q   <= timeout_d;
      echo_byte_q <= echo_byte_d;
    end
  end

  // Next-state logic; retry and timeout override the per-state transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = TX_WAIT;
      TX_WAIT:   if (!is_transmitting) state_d = TX_STROBE;
      TX_STROBE: state_d = TX_HOLD;
      TX_HOLD:   if (is_transmitting) state_d = TX_DRAIN;
      TX_DRAIN:  if (!is_transmitting) state_d = (idx_q == LAST_IDX) ? ECHO_WAIT : TX_STROBE;
      ECHO_WAIT: if (received) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (retry_take_c) begin
      state_d = TX_WAIT;
    end else if (expire_c) begin
      state_d = DONE;
    end
  end

  // Output and datapath logic
  always_comb begin
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    expected_d  = expected_q;
    idx_d       = idx_q;
    wait_cnt_d  = '0;
    tx_byte_d   = tx_byte_q;
    ack_ok_d    = ack_ok_q;
    ack_err_d   = ack_err_q;
    timeout_d   = timeout_q;
    echo_byte_d = echo_byte_q;

    if (accept_c) begin
      data_d     = cmd_data;
      ctrl_d     = cmd_ctrl;
      expected_d = checksum(cmd_data);
      idx_d      = '0;
      ack_ok_d   = 1'b0;
      ack_err_d  = 1'b0;
      timeout_d  = 1'b0;
    end

    if (state_q == TX_DRAIN && !is_transmitting && idx_q != LAST_IDX) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (echo_hit_c) begin
      echo_byte_d = rx_byte;
      if (echo_match_c) begin
        ack_ok_d = 1'b1;
      end else if (!retry_ok_c) begin
        ack_err_d = 1'b1;
      end
    end

    if (expire_c && !retry_ok_c) begin
      timeout_d = 1'b1;
    end

    if (retry_take_c) begin
      idx_d = '0;
    end

    // A retry can re-enter TX_WAIT from TX_WAIT, so it must clear the counter too
    if (in_wait_c && state_d == state_q && !retry_take_c) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    transmit_d = (state_d == TX_STROBE);
    if (transmit_d) begin
      tx_byte_d = frame_byte(data_q, ctrl_q, idx_d);
    end
    busy_d = state_d inside {TX_WAIT, TX_STROBE, TX_HOLD, TX_DRAIN, ECHO_WAIT};
    done_d = (state_d == DONE);
  end

  assign transmit  = transmit_q;
  assign tx_byte   = tx_byte_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_ok    = ack_ok_q;
  assign ack_err   = ack_err_q;
  assign timeout   = timeout_q;
  assign echo_byte = echo_byte_q;

endmodule
